// File: rtl/spi_sclk_cs_gen.sv
// SPI master serial-clock and chip-select generator with CPOL/CPHA modes,
// programmable half-period, start/busy/done handshake, abort and datapath strobes.
module spi_sclk_cs_gen #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned DIV_W      = 8,
   parameter int unsigned NUM_CS     = 1,
   localparam int unsigned CNT_W     = $clog2(FRAME_BITS + 1),
   localparam int unsigned SEL_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DIV_W-1:0]  div,
   input  logic [SEL_W-1:0]  cs_sel,
   output logic              busy,
   output logic              done,
   output logic              dclk,
   output logic [NUM_CS-1:0] cs_n,
   output logic              launch_stb,
   output logic              sample_stb,
   output logic [CNT_W-1:0]  cnt
);

   localparam int unsigned HP_W = (2 * FRAME_BITS > 1) ? $clog2(2 * FRAME_BITS) : 1;
   localparam logic [HP_W-1:0]  HP_LAST   = HP_W'(2 * FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);

   typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

   state_t            state;
   logic              cpol_l;
   logic              cpha_l;
   logic [DIV_W-1:0]  div_l;
   logic [DIV_W-1:0]  dc;
   logic [HP_W-1:0]   hp;

   logic              edge_nxt;
   logic [HP_W-1:0]   eidx;
   logic              lead_e;
   logic              trail_e;
   logic              samp_nxt;
   logic              launch_nxt;

   // dc counts down to 0 over each H-cycle segment. The dclk register must show
   // the new level in the last cycle of a half-period, so the toggle is decided
   // one cycle ahead: when dc is about to reach 0 inside XFER, or when a new
   // half-period of length 1 (div=0) is about to begin.
   always_comb begin
      edge_nxt = 1'b0;
      eidx     = hp;
      case (state)
         LEAD: begin
            eidx     = '0;
            edge_nxt = (dc == '0) && (div_l == '0);
         end
         XFER: begin
            if (dc == DIV_W'(1)) begin
               edge_nxt = 1'b1;
            end else if ((dc == '0) && (div_l == '0) && (hp != HP_LAST)) begin
               edge_nxt = 1'b1;
               eidx     = hp + HP_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Even half-period index -> odd toggle number -> leading edge.
   assign lead_e     = edge_nxt & ~eidx[0];
   assign trail_e    = edge_nxt &  eidx[0];
   assign samp_nxt   = cpha_l ? trail_e : lead_e;
   assign launch_nxt = cpha_l ? lead_e  : (trail_e && (eidx != HP_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cpol_l     <= 1'b1;
         cpha_l     <= 1'b0;
         div_l      <= '0;
         dc         <= '0;
         hp         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dclk       <= 1'b1;
         cs_n       <= '1;
         launch_stb <= 1'b0;
         sample_stb <= 1'b0;
         cnt        <= '0;
      end else begin
         done       <= 1'b0;
         launch_stb <= 1'b0;
         sample_stb <= 1'b0;
         case (state)
            IDLE: begin
               dclk <= cpol;
               if (start) begin
                  state      <= LEAD;
                  cpol_l     <= cpol;
                  cpha_l     <= cpha;
                  div_l      <= div;
                  dc         <= div;
                  hp         <= '0;
                  busy       <= 1'b1;
                  cnt        <= '0;
                  launch_stb <= ~cpha;
                  for (int unsigned i = 0; i < NUM_CS; i++) begin
                     cs_n[i] <= (32'(cs_sel) != i);
                  end
               end else begin
                  cs_n <= '1;
               end
            end
            default: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cs_n  <= '1;
                  dclk  <= cpol_l;
               end else begin
                  if (edge_nxt) begin
                     dclk       <= ~dclk;
                     launch_stb <= launch_nxt;
                     sample_stb <= samp_nxt;
                     if (samp_nxt && (cnt != CNT_FULL)) begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  if (dc == '0) begin
                     dc <= div_l;
                     case (state)
                        LEAD: begin
                           state <= XFER;
                           hp    <= '0;
                        end
                        XFER: begin
                           if (hp == HP_LAST) begin
                              state <= TRAIL;
                           end else begin
                              hp <= hp + HP_W'(1);
                           end
                        end
                        default: begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           cs_n  <= '1;
                           done  <= 1'b1;
                        end
                     endcase
                  end else begin
                     dc <= dc - DIV_W'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sclk_cs_gen.sv
// Directed bench for spi_sclk_cs_gen: modes, chip-select routing, abort,
// reset mid-transfer and back-to-back transfers.
module tb_spi_sclk_cs_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic [7:0] div = 8'd0;
   logic [1:0] cs_sel = 2'd0;
   logic       busy, done, dclk, launch_stb, sample_stb;
   logic [3:0] cs_n;
   logic [4:0] cnt;

   int n_cmp = 0;
   int n_err = 0;

   spi_sclk_cs_gen #(.FRAME_BITS(16), .DIV_W(8), .NUM_CS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cpol(cpol), .cpha(cpha),
      .div(div), .cs_sel(cs_sel), .busy(busy), .done(done), .dclk(dclk), .cs_n(cs_n),
      .launch_stb(launch_stb), .sample_stb(sample_stb), .cnt(cnt)
   );

   always #5 clk = ~clk;

   // expected transfer context, set by the tasks when a transfer is launched
   logic       m_cpol = 1'b0;
   logic       m_cpha = 1'b0;
   logic [1:0] m_sel  = 2'd0;

   // passive event counters (cumulative; tasks take differences)
   logic       pdclk = 1'b1;
   logic       pbusy = 1'b0;
   logic [3:0] pcs = 4'hF;
   logic [3:0] cs_exp;
   logic       dch, ld;
   int n_rise = 0, n_samp = 0, n_samp_good = 0, n_launch = 0, n_launch_still = 0;
   int n_done = 0, cs_err = 0, csrise_err = 0, run = 0, last_run = 0;

   always @(negedge clk) begin
      dch = (dclk !== pdclk);
      ld  = dch && (dclk !== m_cpol);
      if (dch && dclk === 1'b1) n_rise++;
      if (sample_stb === 1'b1) begin
         n_samp++;
         if (m_cpha ? (dch && !ld) : ld) n_samp_good++;
      end
      if (launch_stb === 1'b1) begin
         n_launch++;
         if (!dch) n_launch_still++;
      end
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) run++;
      else if (pbusy === 1'b1) begin
         last_run = run;
         run = 0;
      end
      cs_exp = (busy === 1'b1) ? ~(4'b0001 << m_sel) : 4'hF;
      if (cs_n !== cs_exp) cs_err++;
      if (done === 1'b1 && pcs != 4'hF && cs_n == 4'hF && pdclk !== m_cpol) csrise_err++;
      pdclk = dclk;
      pbusy = busy;
      pcs   = cs_n;
   end

   task automatic go(input logic p, input logic h, input logic [7:0] d, input logic [1:0] s);
      @(posedge clk); #1;
      m_cpol = p; m_cpha = h; m_sel = s;
      cpol = p; cpha = h; div = d; cs_sel = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (dclk !== 1'b1) begin n_err++; $display("FAIL reset_dclk: got %b want 1", dclk); end
      n_cmp++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL reset_cs_n: got %h want f", cs_n); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
      n_cmp++; if (launch_stb !== 1'b0 || sample_stb !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got %b%b want 00", launch_stb, sample_stb); end
      n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (dclk !== 1'b0) begin n_err++; $display("FAIL idle_dclk_cpol0: got %b want 0", dclk); end
   endtask

   task automatic test_mode0;
      int s_rise, s_samp, s_good, s_lau, s_still, s_done, s_cs, s_csr;
      bit ok;
      s_rise = n_rise; s_samp = n_samp; s_good = n_samp_good; s_lau = n_launch;
      s_still = n_launch_still; s_done = n_done; s_cs = cs_err; s_csr = csrise_err;
      go(1'b0, 1'b0, 8'd1, 2'd0);
      wait_done(200, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL m0_timeout: got no done want done"); end
      n_cmp++; if (last_run != 68) begin n_err++; $display("FAIL m0_busy_len: got %0d want 68", last_run); end
      n_cmp++; if (n_rise - s_rise != 16) begin n_err++; $display("FAIL m0_rises: got %0d want 16", n_rise - s_rise); end
      n_cmp++; if (n_samp - s_samp != 16) begin n_err++; $display("FAIL m0_samples: got %0d want 16", n_samp - s_samp); end
      n_cmp++; if (n_samp_good - s_good != 16) begin n_err++; $display("FAIL m0_sample_edge: got %0d want 16", n_samp_good - s_good); end
      n_cmp++; if (n_launch - s_lau != 16) begin n_err++; $display("FAIL m0_launches: got %0d want 16", n_launch - s_lau); end
      n_cmp++; if (n_launch_still - s_still != 1) begin n_err++; $display("FAIL m0_lead_launch: got %0d want 1", n_launch_still - s_still); end
      n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL m0_cnt: got %0d want 16", cnt); end
      n_cmp++; if (n_done - s_done != 1) begin n_err++; $display("FAIL m0_done: got %0d want 1", n_done - s_done); end
      n_cmp++; if (cs_err != s_cs) begin n_err++; $display("FAIL m0_cs: got %0d bad cycles want 0", cs_err - s_cs); end
      n_cmp++; if (csrise_err != s_csr) begin n_err++; $display("FAIL m0_dclk_before_cs: got %0d want 0", csrise_err - s_csr); end
   endtask

   task automatic test_modes;
      int s_samp, s_good, s_lau, s_still, s_done, s_csr;
      bit ok;
      logic [1:0] m;
      for (int k = 1; k <= 3; k++) begin
         m = 2'(k);
         @(posedge clk); #1;
         cpol = m[1];
         repeat (2) @(negedge clk);
         n_cmp++; if (dclk !== m[1]) begin n_err++; $display("FAIL mode%0d_idle_dclk: got %b want %b", k, dclk, m[1]); end
         s_samp = n_samp; s_good = n_samp_good; s_lau = n_launch; s_still = n_launch_still;
         s_done = n_done; s_csr = csrise_err;
         go(m[1], m[0], 8'd0, 2'd1);
         wait_done(100, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL mode%0d_timeout: got no done want done", k); end
         n_cmp++; if (last_run != 34) begin n_err++; $display("FAIL mode%0d_busy_len: got %0d want 34", k, last_run); end
         n_cmp++; if (n_samp - s_samp != 16) begin n_err++; $display("FAIL mode%0d_samples: got %0d want 16", k, n_samp - s_samp); end
         n_cmp++; if (n_samp_good - s_good != 16) begin n_err++; $display("FAIL mode%0d_sample_edge: got %0d want 16", k, n_samp_good - s_good); end
         n_cmp++; if (n_launch - s_lau != 16) begin n_err++; $display("FAIL mode%0d_launches: got %0d want 16", k, n_launch - s_lau); end
         n_cmp++; if (n_launch_still - s_still != (m[0] ? 0 : 1)) begin n_err++; $display("FAIL mode%0d_lead_launch: got %0d want %0d", k, n_launch_still - s_still, m[0] ? 0 : 1); end
         n_cmp++; if (n_done - s_done != 1) begin n_err++; $display("FAIL mode%0d_done: got %0d want 1", k, n_done - s_done); end
         n_cmp++; if (csrise_err != s_csr) begin n_err++; $display("FAIL mode%0d_dclk_before_cs: got %0d want 0", k, csrise_err - s_csr); end
         n_cmp++; if (dclk !== m[1]) begin n_err++; $display("FAIL mode%0d_end_dclk: got %b want %b", k, dclk, m[1]); end
      end
   endtask

   task automatic test_cs_sel;
      int s_cs;
      bit ok;
      s_cs = cs_err;
      go(1'b0, 1'b0, 8'd2, 2'd2);
      repeat (10) @(negedge clk);
      n_cmp++; if (cs_n !== 4'b1011) begin n_err++; $display("FAIL cs2_select: got %b want 1011", cs_n); end
      cs_sel = 2'd3;
      repeat (30) @(negedge clk);
      n_cmp++; if (cs_n !== 4'b1011) begin n_err++; $display("FAIL cs2_hold: got %b want 1011", cs_n); end
      wait_done(200, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL cs2_timeout: got no done want done"); end
      n_cmp++; if (cs_err != s_cs) begin n_err++; $display("FAIL cs2_whole: got %0d bad cycles want 0", cs_err - s_cs); end
      go(1'b0, 1'b0, 8'd2, 2'd3);
      repeat (5) @(negedge clk);
      n_cmp++; if (cs_n !== 4'b0111) begin n_err++; $display("FAIL cs3_select: got %b want 0111", cs_n); end
      wait_done(200, ok);
      n_cmp++; if (!ok || cs_err != s_cs) begin n_err++; $display("FAIL cs3_whole: got %0d bad cycles (done %b) want 0", cs_err - s_cs, ok); end
   endtask

   task automatic test_abort;
      int k, s_done;
      bit hit;
      k = 0; hit = 1'b0;
      s_done = n_done;
      go(1'b0, 1'b0, 8'd2, 2'd1);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sample_stb === 1'b1) k++;
         if (k == 5) begin
            hit = 1'b1;
            abort = 1'b1;
            break;
         end
      end
      n_cmp++; if (!hit) begin n_err++; $display("FAIL abort_reach5: got %0d samples want 5", k); end
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_cmp++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL abort_cs_n: got %h want f", cs_n); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_busy_done: got %b%b want 00", busy, done); end
      n_cmp++; if (dclk !== 1'b0) begin n_err++; $display("FAIL abort_dclk: got %b want 0", dclk); end
      n_cmp++; if (cnt !== 5'd5) begin n_err++; $display("FAIL abort_cnt: got %0d want 5", cnt); end
      n_cmp++; if (launch_stb !== 1'b0 || sample_stb !== 1'b0) begin n_err++; $display("FAIL abort_strobes: got %b%b want 00", launch_stb, sample_stb); end
      abort = 1'b1;
      repeat (10) @(negedge clk);
      abort = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (n_done != s_done || busy !== 1'b0 || cnt !== 5'd5) begin n_err++; $display("FAIL abort_after: got done %0d busy %b cnt %0d want 0 0 5", n_done - s_done, busy, cnt); end
   endtask

   task automatic test_rst_mid;
      int s_done;
      bit ok;
      s_done = n_done;
      go(1'b0, 1'b0, 8'd1, 2'd0);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (dclk !== 1'b1) begin n_err++; $display("FAIL rst_dclk: got %b want 1", dclk); end
      n_cmp++; if (cs_n !== 4'hF || busy !== 1'b0) begin n_err++; $display("FAIL rst_cs_busy: got %h %b want f 0", cs_n, busy); end
      n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
      go(1'b0, 1'b0, 8'd1, 2'd0);
      wait_done(200, ok);
      n_cmp++; if (!ok || last_run != 68) begin n_err++; $display("FAIL rst_rerun_len: got %0d (done %b) want 68", last_run, ok); end
      n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL rst_rerun_cnt: got %0d want 16", cnt); end
      n_cmp++; if (n_done - s_done != 1) begin n_err++; $display("FAIL rst_done_count: got %0d want 1", n_done - s_done); end
   endtask

   task automatic test_back_to_back;
      int s_done;
      bit hit, ok;
      hit = 1'b0;
      go(1'b1, 1'b1, 8'd0, 2'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      n_cmp++; if (!hit || cs_n !== 4'hF) begin n_err++; $display("FAIL b2b_done_cycle: got cs %h (done %b) want f", cs_n, hit); end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s_done = n_done;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || cs_n !== 4'b1110) begin n_err++; $display("FAIL b2b_restart: got busy %b cs %h want 1 e", busy, cs_n); end
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(100, ok);
      n_cmp++; if (!ok || last_run != 34) begin n_err++; $display("FAIL b2b_len: got %0d (done %b) want 34", last_run, ok); end
      repeat (5) @(posedge clk); #1;
      n_cmp++; if (n_done - s_done != 1 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_count: got %0d busy %b want 1 0", n_done - s_done, busy); end
   endtask

   initial begin
      test_reset;
      test_mode0;
      test_modes;
      test_cs_sel;
      test_abort;
      test_rst_mid;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
